// File: rtl/cfg_stream_loader_if.sv
// Stream-in and fabric-config-out bundle for the configuration loader.
// The master side feeds stream words and observes the config write bus;
// the slave side is the loader itself.
interface cfg_stream_loader_if #(
  parameter int ADDR_W = 6
);
  logic [31:0]       in_data;
  logic              in_valid;
  logic              in_ready;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [31:0]       cfg_data;

  modport master (
    output in_data, in_valid,
    input  in_ready, cfg_we, cfg_addr, cfg_data
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, cfg_we, cfg_addr, cfg_data
  );
endinterface

// File: rtl/cfg_stream_loader.sv
// Fabric configuration loader: consumes header, NUM_WORDS payload words and an
// XOR checksum from a valid/ready stream, writes each payload word to the
// fabric config bus, and enables the fabric only after a clean, complete load.
module cfg_stream_loader #(
  parameter int          NUM_WORDS = 57,
  parameter int          ADDR_W    = 6,
  parameter logic [31:0] MAGIC     = 32'hF96A_C0DE,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  cfg_stream_loader_if.slave   bus,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 fabric_en
);

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX     = ADDR_W'(NUM_WORDS - 1);
  localparam logic [31:0]       TIMEOUT_LAST = 32'(TIMEOUT - 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       checksum;
  logic [31:0]       idle_cnt;
  logic              xfer;

  assign xfer = bus.in_valid & bus.in_ready;

  // Load sequencer: state, registered handshake/status outputs and config writes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      checksum     <= '0;
      idle_cnt     <= '0;
      bus.in_ready <= 1'b0;
      bus.cfg_we   <= 1'b0;
      bus.cfg_addr <= '0;
      bus.cfg_data <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      fabric_en    <= 1'b0;
    end else begin
      bus.cfg_we <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state        <= HEADER;
            idx          <= '0;
            checksum     <= '0;
            idle_cnt     <= '0;
            bus.in_ready <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            fabric_en    <= 1'b0;
          end
        end
        default: begin
          if (abort) begin
            state        <= IDLE;
            bus.in_ready <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            fabric_en    <= 1'b0;
          end else if (xfer) begin
            idle_cnt <= '0;
            case (state)
              HEADER: begin
                if (bus.in_data == MAGIC) begin
                  state <= PAYLOAD;
                end else begin
                  state        <= ERROR;
                  bus.in_ready <= 1'b0;
                  busy         <= 1'b0;
                  error        <= 1'b1;
                end
              end
              PAYLOAD: begin
                bus.cfg_we   <= 1'b1;
                bus.cfg_addr <= idx;
                bus.cfg_data <= bus.in_data;
                checksum     <= checksum ^ bus.in_data;
                idx          <= idx + 1'b1;
                if (idx == LAST_IDX) begin
                  state <= CHECK;
                end
              end
              default: begin
                bus.in_ready <= 1'b0;
                busy         <= 1'b0;
                if (bus.in_data == checksum) begin
                  state     <= DONE;
                  done      <= 1'b1;
                  fabric_en <= 1'b1;
                end else begin
                  state <= ERROR;
                  error <= 1'b1;
                end
              end
            endcase
          end else if (TIMEOUT != 0) begin
            if (idle_cnt == TIMEOUT_LAST) begin
              state        <= ERROR;
              bus.in_ready <= 1'b0;
              busy         <= 1'b0;
              error        <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
